// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results and load responses into one
// GPR write per cycle. Load data is formatted at accept, so queue entries hold final
// values. Loads that lose arbitration wait in a small in-order queue.
//
// Build option: define WB_STARVE_GUARD_EN to add alu_stall_o and a starve counter.
// When the counter reaches 3 with loads waiting, the queue head is forced through and
// the ALU is stalled for one cycle.

module wb_arbiter #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned RF_SIZE    = 5,
    parameter int unsigned LQ_DEPTH   = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    // ALU result stream (always accepted unless stalled)
    input  logic                         alu_valid_i,
    input  logic [RF_SIZE-1:0]           alu_rd_i,
    input  logic [DATA_WIDTH-1:0]        alu_data_i,
    // Load response stream
    input  logic                         lsu_valid_i,
    output logic                         lsu_ready_o,
    input  logic [RF_SIZE-1:0]           lsu_rd_i,
    input  logic [2:0]                   lsu_funct3_i,
    input  logic [2:0]                   lsu_addr_lo_i,
    input  logic [DATA_WIDTH-1:0]        lsu_rdata_i,
    // GPR write port
    output logic                         wb_we_o,
    output logic [RF_SIZE-1:0]           wb_rd_o,
    output logic [DATA_WIDTH-1:0]        wb_data_o,
`ifdef WB_STARVE_GUARD_EN
    output logic                         alu_stall_o,
`endif
    output logic [$clog2(LQ_DEPTH):0]    lq_count_o
);

    localparam int unsigned PtrW = $clog2(LQ_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(LQ_DEPTH);

    // ------------------------------------------------------------------
    // Queue state
    // ------------------------------------------------------------------
    logic [PtrW-1:0]       head_q, head_d;
    logic [PtrW-1:0]       tail_q, tail_d;
    logic [CntW-1:0]       count_q, count_d;

    logic [DATA_WIDTH-1:0] lq_data_q [LQ_DEPTH];
    logic [RF_SIZE-1:0]    lq_rd_q   [LQ_DEPTH];
    // Entry carries a real write (funct3 != 111)
    logic                  lq_wr_q   [LQ_DEPTH];

    logic                  lq_empty;
    logic                  accept;
    logic                  alu_win;
    logic                  pop;
    logic                  bypass;
    logic                  push;
    logic                  guard;

    // Formatted load
    logic [DATA_WIDTH-1:0] ld_shifted;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_wr;

    // Writeback next state
    logic                  wb_we_d;
    logic [RF_SIZE-1:0]    wb_rd_d;
    logic [DATA_WIDTH-1:0] wb_data_d;

    assign lq_empty    = (count_q == '0);
    // Ready comes from registered occupancy only, so a full queue never accepts,
    // even when its head drains in the same cycle.
    assign lsu_ready_o = (count_q != CntFull);
    assign accept      = lsu_valid_i && lsu_ready_o;
    assign lq_count_o  = count_q;

    // ------------------------------------------------------------------
    // Starvation guard
    // ------------------------------------------------------------------
`ifdef WB_STARVE_GUARD_EN
    logic [1:0] starve_q, starve_d;

    assign guard       = (starve_q == 2'd3) && !lq_empty;
    assign alu_stall_o = guard;

    // Count consecutive cycles where the ALU beats a waiting load
    always_comb begin
        starve_d = starve_q;
        if (pop) begin
            starve_d = 2'd0;
        end else if (alu_win && !lq_empty) begin
            starve_d = starve_q + 2'd1;
        end
    end

    // Starve counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q <= 2'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign guard = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Load formatting: extract and extend the addressed field at accept time
    // ------------------------------------------------------------------
    always_comb begin
        ld_shifted = lsu_rdata_i >> {lsu_addr_lo_i, 3'b000};
        ld_wr      = 1'b1;
        ld_data    = '0;
        case (lsu_funct3_i)
            3'b000:  ld_data = {{(DATA_WIDTH-8){ld_shifted[7]}}, ld_shifted[7:0]};
            3'b001:  ld_data = {{(DATA_WIDTH-16){ld_shifted[15]}}, ld_shifted[15:0]};
            3'b010:  ld_data = {{(DATA_WIDTH-32){ld_shifted[31]}}, ld_shifted[31:0]};
            3'b011:  ld_data = ld_shifted;
            3'b100:  ld_data = {{(DATA_WIDTH-8){1'b0}}, ld_shifted[7:0]};
            3'b101:  ld_data = {{(DATA_WIDTH-16){1'b0}}, ld_shifted[15:0]};
            3'b110:  ld_data = {{(DATA_WIDTH-32){1'b0}}, ld_shifted[31:0]};
            default: begin
                // Reserved encoding: consumed as a slot but never written
                ld_data = '0;
                ld_wr   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Arbitration: ALU, then queue head, then same-cycle load bypass
    // ------------------------------------------------------------------
    always_comb begin
        alu_win = alu_valid_i && !guard;
        pop     = !alu_win && !lq_empty;
        bypass  = !alu_win && lq_empty && accept;
        push    = accept && !bypass;
    end

    // Select the write for the next edge; rd==0 suppresses the enable only
    always_comb begin
        wb_we_d   = 1'b0;
        wb_rd_d   = wb_rd_o;
        wb_data_d = wb_data_o;
        if (alu_win) begin
            wb_we_d   = (alu_rd_i != '0);
            wb_rd_d   = alu_rd_i;
            wb_data_d = alu_data_i;
        end else if (pop) begin
            wb_we_d   = lq_wr_q[head_q] && (lq_rd_q[head_q] != '0);
            wb_rd_d   = lq_rd_q[head_q];
            wb_data_d = lq_data_q[head_q];
        end else if (bypass) begin
            wb_we_d   = ld_wr && (lsu_rd_i != '0);
            wb_rd_d   = lsu_rd_i;
            wb_data_d = ld_data;
        end
    end

    // Pointer and occupancy next state; pointers wrap on power-of-two depth
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            head_d = head_q + PtrW'(1);
        end
        if (push) begin
            tail_d = tail_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue control registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Queue storage; contents are don't-care while the slot is empty
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            lq_data_q[tail_q] <= ld_data;
            lq_rd_q[tail_q]   <= lsu_rd_i;
            lq_wr_q[tail_q]   <= ld_wr;
        end
    end

    // Registered GPR write port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_we_o   <= 1'b0;
            wb_rd_o   <= '0;
            wb_data_o <= '0;
        end else begin
            wb_we_o   <= wb_we_d;
            wb_rd_o   <= wb_rd_d;
            wb_data_o <= wb_data_d;
        end
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the GPR write port (rd / write-enable / data).
- Merges single-cycle ALU results and variable-latency load responses from the LSU into at most one register write per cycle.
- Formats raw load data: byte/half/word/double extraction with sign or zero extension.
- Buffers load responses that lose arbitration in a small queue.

Parameters:
DATA_WIDTH, 64, width of register data and raw LSU read data
RF_SIZE, 5, register index width (2**RF_SIZE registers)
LQ_DEPTH, 2, load queue entries (power of two, >= 2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
alu_valid_i  input  1  ALU result valid this cycle (no ready; must be taken)
alu_rd_i  input  RF_SIZE  ALU destination register
alu_data_i  input  DATA_WIDTH  ALU result
lsu_valid_i  input  1  load response valid
lsu_ready_o  output  1  load queue can accept a response
lsu_rd_i  input  RF_SIZE  load destination register
lsu_funct3_i  input  3  RV64I load funct3
lsu_addr_lo_i  input  3  byte offset of load address within doubleword
lsu_rdata_i  input  DATA_WIDTH  raw aligned doubleword from memory
wb_we_o  output  1  GPR write enable (registered)
wb_rd_o  output  RF_SIZE  GPR write index (registered)
wb_data_o  output  DATA_WIDTH  GPR write data (registered)
lq_count_o  output  $clog2(LQ_DEPTH)+1  current load queue occupancy

Behaviour:
- Reset (rst_n low at clk edge):
  - wb_we_o=0, wb_rd_o=0, wb_data_o=0.
  - Queue emptied (head=tail=0, count=0), so lsu_ready_o=1 after reset.
  - Applies mid-operation: queued loads are discarded; an in-flight ALU result is dropped.
- Handshake:
  - A load is accepted when lsu_valid_i && lsu_ready_o.
  - lsu_ready_o = (count != LQ_DEPTH). It is derived from registered count only and never depends on a same-cycle pop. When full, no accept occurs even if the head drains that cycle.
- Load formatting, applied at accept so queue entries store final data:
  - shifted = lsu_rdata_i >> (8*lsu_addr_lo_i).
  - funct3 000 LB: sign-extend shifted[7:0]; 001 LH: sign-extend [15:0]; 010 LW: sign-extend [31:0]; 011 LD: shifted.
  - 100 LBU, 101 LHU, 110 LWU: zero-extend [7:0] / [15:0] / [31:0].
  - 111: entry accepted but marked no-write (data 0). It is consumed normally with wb_we_o=0.
  - Misalignment is not checked here; the LSU guarantees alignment.
- Arbitration, evaluated each cycle:
  1. alu_valid_i: ALU result is written next edge.
  2. Else queue non-empty: head popped and written next edge.
  3. Else load accepted this cycle with empty queue: bypasses the queue and is written next edge (load latency 1 cycle, count unchanged).
  4. Else: wb_we_o=0 next edge; wb_rd_o and wb_data_o hold their previous values.
- Accepted loads not written that cycle are pushed at tail.
- Push and pop in the same cycle leave count unchanged.
- Pointers wrap modulo LQ_DEPTH.
- x0: any write with rd==0 gives wb_we_o=0. wb_rd_o and wb_data_o still update; the GPR ignores them.
- Latency: ALU result reaches the GPR write port exactly 1 cycle after alu_valid_i. Loads take 1 cycle plus queue wait.
- Ordering: loads retire in acceptance order. No ordering is enforced between the ALU and LSU streams; the issue stage guarantees no WAW between in-flight loads and ALU ops.
- lq_count_o equals registered count.

Optional Feature:
- Macro WB_STARVE_GUARD_EN.
- Defined:
  - Adds output port alu_stall_o (1 bit) and a 2-bit starve counter.
  - The counter increments on each cycle the queue is non-empty and the ALU wins. It clears on any queue pop or reset.
  - When the counter == 3 and the queue is non-empty:
    - alu_stall_o=1 (combinational).
    - The queue head is written instead of the ALU result; alu_valid_i is ignored that cycle.
    - Upstream holds its ALU result and re-presents it next cycle.
  - alu_stall_o is 0 out of reset.
- Undefined: port and counter are absent, and the ALU always wins.

Test Plan:
- Reset then alu_valid_i=1, rd=5, data=0x1234 -> next cycle wb_we_o=1, wb_rd_o=5, wb_data_o=0x1234; following idle cycle wb_we_o=0.
- LB, addr_lo=3, rdata=0x00000000_80FF0000 (byte 3=0x80), rd=7, queue empty, no ALU -> next cycle wb_we_o=1, rd 7, data 0xFFFFFFFF_FFFFFF80; same stimulus with LBU -> 0x80.
- ALU valid for 4 consecutive cycles while loads to rd 1, 2, 3 arrive back-to-back:
  - lq_count_o goes 1 -> 2; lsu_ready_o drops to 0 on the third load, which is held.
  - After ALU stops: writes rd1, rd2, then the third load accepted and written, in order.
- Queue full (count=2) with simultaneous pop -> lsu_ready_o stays 0 that cycle; accept occurs only the cycle after count drops to 1.
- ALU write with rd=0 data=0xDEAD, and load funct3=111 -> wb_we_o=0 both cycles; queue drains; count returns to 0.
- Reset asserted with 2 queued loads -> next cycle count=0, wb_we_o=0, lsu_ready_o=1, no queued load ever written.
- WB_STARVE_GUARD_EN: queue non-empty and ALU valid every cycle -> fourth cycle alu_stall_o=1 and the load head is written; counter clears; ALU result written the next cycle.
